// File: rtl/flash_audio_sequencer.sv
// Flash playback sequencer: fetches 32-bit words and plays them out as two 16-bit samples.
// Optional macro SEQ_TIMEOUT_EN re-issues start when finished does not arrive within TIMEOUT_CYC cycles.
module flash_audio_sequencer #(
    parameter int                ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] ADDR_MAX    = 23'h7FFFF,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sample_tick_i,
    input  logic              play_i,
    input  logic              forward_i,
    input  logic              restart_i,
    input  logic              finished_i,
    input  logic [31:0]       flash_readdata_i,
    output logic              start_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [15:0]       audio_out_o,
    output logic              audio_valid_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_FIN = 3'd2,
        WAIT_S0  = 3'd3,
        WAIT_S1  = 3'd4,
        ADVANCE  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [31:0]       word_q, word_d;
    logic              dir_q, dir_d;
    logic              restart_q, restart_d;
    logic              start_q, start_d;
    logic [15:0]       audio_q, audio_d;
    logic              valid_q, valid_d;
    logic              restart_now_s;
    logic [ADDR_W-1:0] restart_addr_s;
    logic [15:0]       s0_s, s1_s;
`ifdef SEQ_TIMEOUT_EN
    logic [7:0]        tmo_q, tmo_d;
`endif

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] addr, input logic fwd);
        logic [ADDR_W-1:0] res;
        if (fwd) begin
            res = (addr == ADDR_MAX) ? {ADDR_W{1'b0}} : addr + ADDR_W'(1);
        end else begin
            res = (addr == {ADDR_W{1'b0}}) ? ADDR_MAX : addr - ADDR_W'(1);
        end
        return res;
    endfunction

    // Reverse playback swaps the half-word order so the waveform runs backwards too.
    assign s0_s           = dir_q ? word_q[15:0]  : word_q[31:16];
    assign s1_s           = dir_q ? word_q[31:16] : word_q[15:0];
    assign restart_now_s  = restart_q | restart_i;
    assign restart_addr_s = forward_i ? {ADDR_W{1'b0}} : ADDR_MAX;

    // Next-state and datapath update logic.
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        word_d    = word_q;
        dir_d     = dir_q;
        audio_d   = audio_q;
        valid_d   = 1'b0;
        restart_d = restart_now_s;
`ifdef SEQ_TIMEOUT_EN
        tmo_d     = 8'd0;
`endif
        case (state_q)
            IDLE: begin
                if (restart_now_s) begin
                    address_d = restart_addr_s;
                    restart_d = 1'b0;
                end else begin
                    address_d = address_q;
                end
                if (play_i) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                dir_d   = forward_i;
                state_d = WAIT_FIN;
            end
            WAIT_FIN: begin
                if (finished_i) begin
                    word_d  = flash_readdata_i;
                    state_d = WAIT_S0;
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    if (tmo_q == 8'(TIMEOUT_CYC - 1)) begin
                        state_d = REQ;
                    end else begin
                        tmo_d   = tmo_q + 8'd1;
                        state_d = WAIT_FIN;
                    end
`else
                    state_d = WAIT_FIN;
`endif
                end
            end
            WAIT_S0: begin
                if (sample_tick_i && play_i) begin
                    audio_d = s0_s;
                    valid_d = 1'b1;
                    state_d = WAIT_S1;
                end else begin
                    state_d = WAIT_S0;
                end
            end
            WAIT_S1: begin
                if (sample_tick_i && play_i) begin
                    audio_d = s1_s;
                    valid_d = 1'b1;
                    state_d = ADVANCE;
                end else begin
                    state_d = WAIT_S1;
                end
            end
            ADVANCE: begin
                if (restart_now_s) begin
                    address_d = restart_addr_s;
                end else begin
                    address_d = step_addr(address_q, forward_i);
                end
                restart_d = 1'b0;
                if (play_i) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        start_d = (state_d == REQ);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            address_q <= {ADDR_W{1'b0}};
            word_q    <= 32'd0;
            dir_q     <= 1'b1;
            restart_q <= 1'b0;
            start_q   <= 1'b0;
            audio_q   <= 16'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            word_q    <= word_d;
            dir_q     <= dir_d;
            restart_q <= restart_d;
            start_q   <= start_d;
            audio_q   <= audio_d;
            valid_q   <= valid_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Watchdog counter for a missing finished pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign start_o       = start_q;
    assign address_o     = address_q;
    assign audio_out_o   = audio_q;
    assign audio_valid_o = valid_q;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Directed bench for flash_audio_sequencer with a transaction-level model checked every cycle.
module tb_flash_audio_sequencer;
    localparam logic [22:0] AMAX = 23'h7FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        play = 1'b0;
    logic        forward = 1'b1;
    logic        restart = 1'b0;
    logic        finished = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        start_o;
    logic [22:0] address_o;
    logic [15:0] audio_out_o;
    logic        audio_valid_o;

    int checks = 0;
    int errors = 0;

    flash_audio_sequencer dut (
        .clk_i(clk), .reset_i(reset), .sample_tick_i(sample_tick), .play_i(play),
        .forward_i(forward), .restart_i(restart), .finished_i(finished),
        .flash_readdata_i(rdata), .start_o(start_o), .address_o(address_o),
        .audio_out_o(audio_out_o), .audio_valid_o(audio_valid_o)
    );

    always #5 clk = ~clk;

    // Model: expected sample queue, expected next read address, pending restart.
    logic [15:0] exp_q[$];
    logic [22:0] m_addr = 23'd0;
    logic        m_rst_pend = 1'b0, m_out = 1'b0, m_dir = 1'b1;
    logic        prev_start = 1'b0, prev_tp = 1'b0;
    logic [15:0] m_last = 16'd0;
    int          m_nsamp = 0;

    function automatic logic [22:0] step(input logic [22:0] a, input logic fwd);
        if (fwd) return (a == AMAX) ? 23'd0 : a + 23'd1;
        else     return (a == 23'd0) ? AMAX : a - 23'd1;
    endfunction

    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            checks++;
            if (start_o !== 1'b0 || address_o !== 23'd0 || audio_out_o !== 16'd0 || audio_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs start=%0b addr=%h audio=%h valid=%0b required all zero",
                         start_o, address_o, audio_out_o, audio_valid_o);
            end
            exp_q.delete();
            m_addr = 23'd0; m_rst_pend = 1'b0; m_out = 1'b0; m_nsamp = 0;
            m_last = 16'd0; prev_start = 1'b0; prev_tp = 1'b0;
        end else begin
            if (finished && m_out) begin
                if (m_dir) begin exp_q.push_back(rdata[15:0]);  exp_q.push_back(rdata[31:16]); end
                else       begin exp_q.push_back(rdata[31:16]); exp_q.push_back(rdata[15:0]);  end
                m_out = 1'b0;
            end
            if (start_o === 1'b1) begin
                checks++;
                if (address_o !== m_addr) begin
                    errors++; $display("FAIL start_addr actual=%h required=%h", address_o, m_addr);
                end
                checks++;
                if (prev_start) begin
                    errors++; $display("FAIL start_double actual=consecutive required=single");
                end
                m_dir = forward;
                m_out = 1'b1;
            end
            if (restart) m_rst_pend = 1'b1;
            if (audio_valid_o === 1'b1) begin
                checks++;
                if (!prev_tp) begin
                    errors++; $display("FAIL valid_without_tick actual=1 required=0");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_sample actual=%h required=none", audio_out_o);
                end else begin
                    e = exp_q.pop_front();
                    if (audio_out_o !== e) begin
                        errors++; $display("FAIL sample actual=%h required=%h", audio_out_o, e);
                    end
                    m_last = e;
                end
                m_nsamp++;
                if (m_nsamp == 2) begin
                    m_nsamp = 0;
                    m_addr = m_rst_pend ? (forward ? 23'd0 : AMAX) : step(m_addr, forward);
                    m_rst_pend = 1'b0;
                end
            end else begin
                checks++;
                if (audio_out_o !== m_last) begin
                    errors++; $display("FAIL audio_held actual=%h required=%h", audio_out_o, m_last);
                end
            end
            prev_start = (start_o === 1'b1);
            prev_tp = sample_tick & play;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_start(output logic [22:0] a);
        int n;
        n = 0;
        while (start_o !== 1'b1 && n < 64) begin cyc(1); n++; end
        chk("start_seen", {31'd0, start_o}, 32'd1);
        a = address_o;
    endtask

    task automatic tick(output logic v, output logic [15:0] s);
        sample_tick = 1'b1;
        cyc(1);
        v = audio_valid_o;
        s = audio_out_o;
        sample_tick = 1'b0;
        cyc(1);
    endtask

    task automatic respond(input logic [31:0] w);
        cyc(3);
        finished = 1'b1; rdata = w;
        cyc(1);
        finished = 1'b0; rdata = $urandom;
    endtask

    task automatic do_word(input logic [31:0] w, input logic fwd,
                           output logic [22:0] a, output logic [15:0] s0, output logic [15:0] s1);
        logic v0, v1;
        wait_start(a);
        forward = fwd;
        respond(w);
        tick(v0, s0);
        tick(v1, s1);
        chk("valid_s0", {31'd0, v0}, 32'd1);
        chk("valid_s1", {31'd0, v1}, 32'd1);
    endtask

    initial begin
        logic [22:0] a;
        logic [15:0] s0, s1, s;
        logic v;
        int nv, gap;

        cyc(3);
        chk("rst_start", {31'd0, start_o}, 32'd0);
        chk("rst_addr", {9'd0, address_o}, 32'd0);
        chk("rst_audio", {16'd0, audio_out_o}, 32'd0);
        reset = 1'b0; play = 1'b1; forward = 1'b1;

        do_word(32'hAAAA_5555, 1'b1, a, s0, s1);
        chk("w1_addr", {9'd0, a}, 32'd0);
        chk("w1_s0", {16'd0, s0}, 32'h5555);
        chk("w1_s1", {16'd0, s1}, 32'hAAAA);

        do_word(32'h0BAD_F00D, 1'b0, a, s0, s1);
        chk("w2_addr", {9'd0, a}, 32'd1);
        chk("w2_s0", {16'd0, s0}, 32'h0BAD);
        chk("w2_s1", {16'd0, s1}, 32'hF00D);

        do_word(32'h1234_5678, 1'b0, a, s0, s1);
        chk("rev_addr", {9'd0, a}, 32'd0);
        chk("rev_s0", {16'd0, s0}, 32'h1234);
        chk("rev_s1", {16'd0, s1}, 32'h5678);

        do_word(32'hCAFE_BEEF, 1'b1, a, s0, s1);
        chk("wrap_rev_addr", {9'd0, a}, 32'h7FFFF);
        chk("fwd_s0", {16'd0, s0}, 32'hBEEF);

        // Pause in WAIT_S1.
        wait_start(a);
        chk("wrap_fwd_addr", {9'd0, a}, 32'd0);
        respond(32'h1111_2222);
        tick(v, s);
        chk("pause_s0", {16'd0, s}, 32'h2222);
        play = 1'b0;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            tick(v, s);
            if (v) nv++;
        end
        chk("pause_valids", nv, 0);
        chk("pause_held", {16'd0, audio_out_o}, 32'h2222);
        play = 1'b1;
        tick(v, s);
        chk("resume_valid", {31'd0, v}, 32'd1);
        chk("resume_s1", {16'd0, s}, 32'h1111);

        for (int i = 1; i < 100; i++) begin
            do_word(32'h0101_0000 + i, 1'b1, a, s0, s1);
            chk("walk_addr", {9'd0, a}, i);
        end

        // Restart during WAIT_S0 at address 100.
        wait_start(a);
        chk("addr_100", {9'd0, a}, 32'd100);
        respond(32'h6464_0064);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        tick(v, s);
        chk("rs_s0", {15'd0, v, s}, 32'h1_0064);
        tick(v, s);
        chk("rs_s1", {15'd0, v, s}, 32'h1_6464);
        wait_start(a);
        chk("restart_addr", {9'd0, a}, 32'd0);

        // Asynchronous reset in WAIT_FIN, then a stale finished.
        cyc(2);
        reset = 1'b1;
        #1;
        chk("async_rst", {9'd0, start_o, address_o, audio_out_o[0], audio_valid_o}, 32'd0);
        chk("async_rst_audio", {16'd0, audio_out_o}, 32'd0);
        cyc(1);
        reset = 1'b0; play = 1'b0;
        cyc(1);
        finished = 1'b1; rdata = 32'hFFFF_FFFF;
        cyc(1);
        finished = 1'b0;
        nv = 0;
        for (int i = 0; i < 2; i++) begin
            tick(v, s);
            if (v) nv++;
        end
        chk("stale_fin_valids", nv, 0);
        chk("stale_fin_audio", {16'd0, audio_out_o}, 32'd0);
        chk("stale_fin_start", {31'd0, start_o}, 32'd0);

        // Withhold finished.
        play = 1'b1;
        wait_start(a);
        chk("tmo_addr", {9'd0, a}, 32'd0);
        gap = 0;
        for (int i = 1; i <= 300; i++) begin
            cyc(1);
            if (start_o === 1'b1 && gap == 0) gap = i;
        end
`ifdef SEQ_TIMEOUT_EN
        chk("timeout_gap", gap, 256);
`else
        chk("no_second_start", gap, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flash_audio_sequencer.md
# flash_audio_sequencer

Playback sequencer sitting directly downstream of the flash read FSM in the iPod datapath. It owns the flash word address and pulses `start` to request one 32-bit word. It consumes `finished` and the returned data, then splits each word into two 16-bit audio samples released one per `sample_tick`. It also provides play/pause, forward/reverse, restart and address wrap-around.

## Interface
- `ADDR_W`, 23: flash word address width.
- `ADDR_MAX`, 23'h7FFFF: last valid word address; the wrap point.
- `TIMEOUT_CYC`, 255: cycles to wait for `finished` before re-issuing `start` (used only with `SEQ_TIMEOUT_EN`).

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_tick`  in  1  one-cycle strobe at the audio sample rate.
- `play`  in  1  1 = run, 0 = pause.
- `forward`  in  1  1 = ascending addresses, 0 = descending (reverse playback).
- `restart`  in  1  one-cycle pulse; return to the start address.
- `finished`  in  1  one-cycle pulse from the read FSM; `flash_readdata` is valid in this cycle.
- `flash_readdata`  in  32  word returned from flash.
- `start`  out  1  one-cycle request pulse to the read FSM.
- `address`  out  ADDR_W  current flash word address.
- `audio_out`  out  16  current sample; held between updates.
- `audio_valid`  out  1  one-cycle strobe when `audio_out` updates.

## Operation
- States: IDLE, REQ, WAIT_FIN, WAIT_S0, WAIT_S1, ADVANCE.
- IDLE: if `play`=1, go to REQ; otherwise stay.
- REQ:
  - `start`=1 for exactly this cycle.
  - Latch `forward` as `dir_l`.
  - Go to WAIT_FIN.
- WAIT_FIN: on `finished`=1, capture `flash_readdata` into `word_r` and go to WAIT_S0.
- Sample order depends on `dir_l`:
  - `dir_l`=1: S0 = `word_r[15:0]`, S1 = `word_r[31:16]`.
  - `dir_l`=0: S0 = `word_r[31:16]`, S1 = `word_r[15:0]`. This gives true reverse playback.
- WAIT_S0: on `sample_tick`=1 with `play`=1, load S0 into `audio_out`, pulse `audio_valid`, go to WAIT_S1.
- WAIT_S1: same as WAIT_S0 but loads S1, then goes to ADVANCE.
- In WAIT_S0/WAIT_S1 with `play`=0: ticks are ignored and the state is held. This is pause; `audio_out` holds its value.
- ADVANCE:
  - Apply the current `forward` to step `address`.
  - Then go to REQ if `play`=1, otherwise IDLE.
- Address step:
  - Forward: `ADDR_MAX` → 0, else +1.
  - Reverse: 0 → `ADDR_MAX`, else −1.
  - All arithmetic is unsigned, ADDR_W bits.
- `restart` is latched into a sticky flag in any state and consumed at the next ADVANCE or IDLE.
  - At that point `address` loads 0 if `forward`=1, else `ADDR_MAX`, instead of stepping.
  - Samples of the current word still finish playing.
- `sample_tick` outside WAIT_S0/WAIT_S1 is dropped; ticks are not queued.
- `finished` outside WAIT_FIN is ignored.

## Timing
- Reset values: `start`=0, `address`=0, `audio_out`=0, `audio_valid`=0, restart flag = 0, state = IDLE.
- Reset mid-operation takes effect immediately (asynchronous). A read already in flight in the read FSM may later return `finished`; it is ignored in IDLE.
- `start` goes high on the first edge after entering REQ and is never high on two consecutive cycles.
- `flash_readdata` is sampled on the same edge on which `finished`=1.
- `audio_out` and `audio_valid` update on the edge where `sample_tick`=1 is seen in WAIT_S0/WAIT_S1: one-cycle latency.
- Minimum spacing from `finished` to the next `start` is 2 `sample_tick`s plus 2 cycles. The tick period must exceed the read latency; otherwise ticks are dropped.
- `restart` and an ADVANCE step in the same cycle: `restart` wins.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - An 8-bit counter runs in WAIT_FIN.
  - If `finished` has not arrived after `TIMEOUT_CYC` cycles, go back to REQ and re-issue `start` for the same address.
  - The counter clears on leaving WAIT_FIN.
- `SEQ_TIMEOUT_EN` undefined: WAIT_FIN waits indefinitely, and no counter is built.

## Test plan
- Reset, `play`=1, `forward`=1, read model returns 32'hAAAA_5555 → `start` pulses once at `address`=0; the next two ticks give `audio_out`=16'h5555 then 16'hAAAA; then `address`=1 and `start` pulses again.
- `forward`=0 from `address`=0, word 32'h1234_5678 → samples 16'h1234 then 16'h5678; `address` wraps to 23'h7FFFF.
- Forward at `address`=23'h7FFFF → after two samples, `address`=0.
- Drop `play` in WAIT_S1 and apply 5 ticks → no `audio_valid`, `audio_out` held. Raise `play` → next tick emits S1.
- Pulse `restart` during WAIT_S0 at `address`=100 with `forward`=1 → both samples still emitted, then `address`=0 and `start` pulses. Assert `reset` mid-WAIT_FIN → all outputs 0, and a later `finished` is ignored.
- With `SEQ_TIMEOUT_EN`, withhold `finished` → second `start` after 255 cycles at the same address. Without the macro → no second `start`.
